// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared state encoding and sizing helpers for the multiplier arbiter
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } arb_state_e;

    // Requester tag width; a 2-requester build still needs one bit of tag.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, searching upward from ptr_i
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o,
    output logic            any_grant_o
);

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int p;
            p = (int'(ptr_i) + k) % NREQ;
            if (!any_grant_o && req_i[p]) begin
                any_grant_o = 1'b1;
                grant_idx_o = IDW'(p);
                grant_o[p]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wallaceTreeMultiplier.sv
// rtl/wallaceTreeMultiplier.sv - combinational unsigned NxN multiplier, carry-save reduced
module wallaceTreeMultiplier #(
    parameter int N = 8
) (
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] product_o
);

    logic [2*N-1:0] sum;
    logic [2*N-1:0] carry;
    logic [2*N-1:0] pp;

    // Each partial product is folded into a sum/carry pair by a 3:2 compressor;
    // the single carry-propagate add happens once at the end.
    always_comb begin
        sum   = '0;
        carry = '0;
        pp    = '0;
        for (int i = 0; i < N; i++) begin
            pp = b_i[i] ? ({{N{1'b0}}, a_i} << i) : '0;
            {sum, carry} = {sum ^ carry ^ pp,
                            ((sum & carry) | (sum & pp) | (carry & pp)) << 1};
        end
        product_o = sum + carry;
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// rtl/mult_share_arbiter.sv - round-robin sharing of one multiplier between NREQ requesters
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int N    = 8,
    parameter  int NREQ = 4,
    parameter  int CNTW = 16,
    localparam int IDW  = id_width(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2*N-1:0]    res_data,
    output logic [IDW-1:0]    res_id,
    output logic              busy,
    output logic [CNTW-1:0]   ops_done
);

    arb_state_e      state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [IDW-1:0]  id_q;
    logic [N-1:0]    op_a_q;
    logic [N-1:0]    op_b_q;
    logic [2*N-1:0]  res_data_q;
    logic [IDW-1:0]  res_id_q;
    logic            res_valid_q;
    logic [CNTW-1:0] ops_q;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            any_grant;
    logic [IDW-1:0]  rr_ptr_d;
    logic [2*N-1:0]  product;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    wallaceTreeMultiplier #(.N(N)) u_mult (
        .a_i       (op_a_q),
        .b_i       (op_b_q),
        .product_o (product)
    );

    // NREQ need not be a power of two, so the wrap is explicit.
    assign rr_ptr_d  = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);
    assign ops_done  = ops_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            ops_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_grant) begin
                        op_a_q   <= req_a[int'(grant_idx)*N +: N];
                        op_b_q   <= req_b[int'(grant_idx)*N +: N];
                        id_q     <= grant_idx;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    res_data_q  <= product;
                    res_id_q    <= id_q;
                    res_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        ops_q       <= ops_q + CNTW'(1);
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb/tb_mult_share_arbiter.sv - self-checking bench for mult_share_arbiter
module tb_mult_share_arbiter;

    localparam int N    = 8;
    localparam int NREQ = 4;
    localparam int CNTW = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic              res_valid;
    logic              res_ready;
    logic [2*N-1:0]    res_data;
    logic [IDW-1:0]    res_id;
    logic              busy;
    logic [CNTW-1:0]   ops_done;

    mult_share_arbiter #(.N(N), .NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: phase 0 = waiting for a request, 1 = multiplying, 2 = offering result.
    int          m_phase = 0;
    int          m_ptr   = 0;
    int          m_cnt   = 0;
    int          m_id    = 0;
    int          m_pid   = 0;
    logic [15:0] m_data  = '0;
    logic [15:0] m_pend  = '0;
    bit          m_valid = 1'b0;

    int          log_id[$];
    logic [15:0] log_d[$];

    function automatic int winner();
        for (int k = 0; k < NREQ; k++)
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_ptr = 0; m_cnt = 0; m_id = 0; m_pid = 0;
            m_data = '0; m_pend = '0; m_valid = 1'b0;
        end else if (m_phase == 0) begin
            int w;
            w = winner();
            if (w >= 0) begin
                m_pend  = 16'(int'(req_a[w*N +: N]) * int'(req_b[w*N +: N]));
                m_pid   = w;
                m_ptr   = (w + 1) % NREQ;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_data  = m_pend;
            m_id    = m_pid;
            m_valid = 1'b1;
            m_phase = 2;
        end else if (res_ready) begin
            m_valid = 1'b0;
            m_cnt   = (m_cnt + 1) % (1 << CNTW);
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            int w;
            logic [NREQ-1:0] exp_rdy;
            w = winner();
            exp_rdy = (m_phase == 0 && w >= 0) ? NREQ'(1 << w) : '0;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("res_valid", 32'(res_valid), 32'(m_valid));
            chk("res_data",  32'(res_data),  32'(m_data));
            chk("res_id",    32'(res_id),    32'(m_id));
            chk("busy",      32'(busy),      32'(m_phase != 0));
            chk("ops_done",  32'(ops_done),  32'(m_cnt));
            if (res_valid && res_ready) begin
                log_id.push_back(int'(res_id));
                log_d.push_back(res_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_op(input int idx, input logic [7:0] a, input logic [7:0] b);
        req_a[idx*N +: N] = a;
        req_b[idx*N +: N] = b;
        req_valid = NREQ'(1 << idx);
        tick();
        req_valid = '0;
        tick();
        tick();
    endtask

    int base;
    int saved_ops;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        tick();
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_ops_done",  32'(ops_done),  32'd0);
        chk("rst_res_data",  32'(res_data),  32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        tick();
        rst_n = 1'b1;

        // single request 3*5
        res_ready = 1'b1;
        req_a[7:0] = 8'd3;
        req_b[7:0] = 8'd5;
        req_valid  = 4'b0001;
        #1 chk("t1_req_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        chk("t1_res_valid", 32'(res_valid), 32'd1);
        chk("t1_res_data",  32'(res_data),  32'd15);
        chk("t1_res_id",    32'(res_id),    32'd0);
        tick();
        chk("t1_ops_done",  32'(ops_done),  32'd1);
        chk("t1_idle",      32'(busy),      32'd0);

        // fresh pointer, then all requesters valid
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        chk("rst2_ops_done", 32'(ops_done), 32'd0);
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = 8'(i + 1);
            req_b[i*N +: N] = 8'd10;
        end
        base = log_d.size();
        req_valid = 4'hF;
        repeat (13) tick();
        req_valid = '0;
        repeat (3) tick();
        chk("t2_count", 32'(log_d.size() - base), 32'd5);
        if (log_d.size() - base == 5) begin
            chk("t2_d0", 32'(log_d[base+0]), 32'd10);
            chk("t2_d1", 32'(log_d[base+1]), 32'd20);
            chk("t2_d2", 32'(log_d[base+2]), 32'd30);
            chk("t2_d3", 32'(log_d[base+3]), 32'd40);
            chk("t2_d4", 32'(log_d[base+4]), 32'd10);
            chk("t2_i0", 32'(log_id[base+0]), 32'd0);
            chk("t2_i1", 32'(log_id[base+1]), 32'd1);
            chk("t2_i2", 32'(log_id[base+2]), 32'd2);
            chk("t2_i3", 32'(log_id[base+3]), 32'd3);
            chk("t2_i4", 32'(log_id[base+4]), 32'd0);
        end

        // extreme operands on a lone requester, operands disturbed after sampling
        base = log_d.size();
        req_a[2*N +: N] = 8'hFF;
        req_b[2*N +: N] = 8'hFF;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        req_a[2*N +: N] = 8'h5A;
        req_a[0 +: N]   = 8'h77;
        tick();
        tick();
        do_op(2, 8'h00, 8'hAB);
        chk("t3_count", 32'(log_d.size() - base), 32'd2);
        if (log_d.size() - base == 2) begin
            chk("t3_ff", 32'(log_d[base]),   32'hFE01);
            chk("t3_00", 32'(log_d[base+1]), 32'h0000);
            chk("t3_id", 32'(log_id[base]),  32'd2);
        end

        // backpressure: result held while other requesters wait
        saved_ops = int'(ops_done);
        res_ready = 1'b0;
        req_a[1*N +: N] = 8'd7;
        req_b[1*N +: N] = 8'd9;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'hF;
        repeat (12) tick();
        chk("t4_res_valid", 32'(res_valid), 32'd1);
        chk("t4_res_data",  32'(res_data),  32'd63);
        chk("t4_res_id",    32'(res_id),    32'd1);
        chk("t4_req_ready", 32'(req_ready), 32'd0);
        chk("t4_busy",      32'(busy),      32'd1);
        chk("t4_ops_held",  32'(ops_done),  32'(saved_ops));
        req_valid = '0;
        res_ready = 1'b1;
        tick();
        chk("t4_released",  32'(res_valid), 32'd0);
        chk("t4_ops_inc",   32'(ops_done),  32'((saved_ops + 1) % 16));
        chk("t4_idle",      32'(busy),      32'd0);

        // reset while multiplying discards the operation
        base = log_d.size();
        req_a[0 +: N] = 8'd9;
        req_b[0 +: N] = 8'd9;
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        #1 rst_n = 1'b0;
        #1;
        chk("t5_res_valid", 32'(res_valid), 32'd0);
        chk("t5_busy",      32'(busy),      32'd0);
        chk("t5_ops_done",  32'(ops_done),  32'd0);
        #2 rst_n = 1'b1;
        req_valid = 4'hF;
        #1 chk("t5_grant0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("t5_one_result", 32'(log_d.size() - base), 32'd1);
        if (log_d.size() - base == 1) begin
            chk("t5_id",   32'(log_id[base]), 32'd0);
            chk("t5_data", 32'(log_d[base]),  32'd81);
        end

        // counter wrap (CNTW=4)
        for (int k = 0; k < 20 && ops_done != 4'hF; k++)
            do_op(k % NREQ, 8'(k), 8'd3);
        chk("t6_at_max", 32'(ops_done), 32'hF);
        do_op(3, 8'd2, 8'd2);
        chk("t6_wrap", 32'(ops_done), 32'd0);

        repeat (2) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
